clint_timer: RTL and testbench
==============================

CLINT_TIMER -- requirements
Module: clint_timer

Interface
REQ-001 SHALL have parameters, one per line:
- BASE_ADDR, 32'h0200_0000, 64 KiB-aligned window base
- PRESCALE, 1, clk cycles per mtime tick (used only under CLINT_PRESCALER_EN, range 1..65535)

REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- memory_valid  in  1  request present, held until memory_ready
- memory_instr  in  1  request is a fetch
- memory_addr  in  32  byte address
- memory_wdata  in  32  write data
- memory_wstrb  in  4  byte enables; 0 means read
- memory_rdata  out  32  read data, valid with memory_ready
- memory_ready  out  1  one-cycle response strobe
- mtime  out  64  free-running time counter
- mtip  out  1  timer interrupt pending
- msip  out  1  software interrupt pending

Function
REQ-003 SHALL select a request when memory_valid=1 and memory_addr[31:16]==BASE_ADDR[31:16]; unselected requests SHALL leave memory_ready=0.
REQ-004 SHALL implement FSM IDLE->RESP on a selected request, and RESP->IDLE unconditionally after one cycle; memory_ready=1 only in RESP, so latency is exactly one cycle.
REQ-005 SHALL NOT accept a new request in RESP; back-to-back accesses therefore complete every second cycle.
REQ-006 SHALL decode offset memory_addr[15:2]:
- 0x0000: msip (bit0)
- 0x4000: mtimecmp[31:0]
- 0x4004: mtimecmp[63:32]
- 0xBFF8: mtime[31:0]
- 0xBFFC: mtime[63:32]
REQ-007 SHALL apply writes per byte lane from memory_wstrb on the accept cycle; other offsets read 0, ignore writes, and still complete.
REQ-008 SHALL treat memory_instr=1 requests as reads.
REQ-009 SHALL register memory_rdata on accept; it holds the value current before any same-cycle write, and is 0 outside RESP.
REQ-010 SHALL increment mtime by 1 modulo 2^64 on each tick, wrapping 0xFFFF_FFFF_FFFF_FFFF->0.
REQ-011 SHALL give a software write to mtime priority over the tick in the same cycle; no increment occurs that cycle.
REQ-012 SHALL register mtip = (mtime >= mtimecmp) each cycle, unsigned 64-bit, using post-update values; mtip SHALL lag by one cycle.
REQ-013 SHALL drive msip directly from the msip register bit0.

Reset
REQ-014 SHALL, on rst=1 asynchronously, set FSM=IDLE, memory_ready=0, memory_rdata=0, mtime=0, mtimecmp=all ones, msip=0, mtip=0.
REQ-015 SHALL discard any in-flight response on reset mid-transaction; no memory_ready follows reset.

Configuration
REQ-016 SHALL implement a prescaler when macro CLINT_PRESCALER_EN is defined: a 16-bit counter ticks mtime once every PRESCALE cycles, resets to 0, and restarts on any mtime write.
REQ-017 SHALL, when CLINT_PRESCALER_EN is undefined, tick mtime every cycle, ignore PRESCALE, and instantiate no prescaler logic.

Verification
REQ-018 Scenarios:
- Read 0x0200BFF8 at cycle 10 after reset (no prescaler) -> memory_ready at cycle 11, rdata=10 ±1 per implementation-fixed offset, checked against a model.
- Write mtimecmp = 0x0000_0000_0000_0020 (hi then lo, wstrb=4'hF) -> mtip rises exactly one cycle after mtime reaches 0x20.
- Write mtime hi/lo = 0xFFFF_FFFF_FFFF_FFFE -> after 2 ticks mtime=0, mtip drops if mtimecmp>0.
- Write 0x02000000 wdata=1 wstrb=4'h1 -> msip=1; wstrb=4'h2 with wdata=0 -> msip unchanged.
- Request to 0x03000000 held valid 5 cycles -> memory_ready stays 0; read 0x02001234 -> ready, rdata=0.
- Assert rst during RESP -> memory_ready=0 next cycle, mtime=0, mtimecmp=all ones; with CLINT_PRESCALER_EN and PRESCALE=4, mtime increments every 4th cycle.

Source files
------------

// File: rtl/clint_timer.sv
// CLINT-style machine timer and software interrupt block on a valid/ready bus.
// Define CLINT_PRESCALER_EN to divide the mtime tick by PRESCALE.
`timescale 1ns/1ps
module clint_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
    parameter int          PRESCALE  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_valid,
    input  logic        memory_instr,
    input  logic [31:0] memory_addr,
    input  logic [31:0] memory_wdata,
    input  logic [3:0]  memory_wstrb,
    output logic [31:0] memory_rdata,
    output logic        memory_ready,
    output logic [63:0] mtime,
    output logic        mtip,
    output logic        msip
);
    typedef enum logic {S_IDLE, S_RESP} state_t;

    localparam logic [13:0] OFF_MSIP  = 14'h0000;
    localparam logic [13:0] OFF_CMPLO = 14'h1000;
    localparam logic [13:0] OFF_CMPHI = 14'h1001;
    localparam logic [13:0] OFF_TLO   = 14'h2FFE;
    localparam logic [13:0] OFF_THI   = 14'h2FFF;

    if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
        $error("clint_timer: PRESCALE must be 1..65535");
    end

    state_t      r_state;
    state_t      w_next;
    logic        w_sel;
    logic        w_accept;
    logic        w_wr;
    logic        w_wr_msip;
    logic        w_wr_clo;
    logic        w_wr_chi;
    logic        w_wr_tlo;
    logic        w_wr_thi;
    logic        w_tick;
    logic        w_unused;
    logic [13:0] w_off;
    logic [31:0] w_rd;
    logic [31:0] r_rdata;
    logic [63:0] r_mtime;
    logic [63:0] r_cmp;
    logic        r_msip;
    logic        r_mtip;

    function automatic logic [31:0] f_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    assign w_off     = memory_addr[15:2];
    assign w_unused  = ^memory_addr[1:0];
    assign w_sel     = memory_valid &&
                       (memory_addr[31:16] == BASE_ADDR[31:16]);
    // Fetches are served as reads and never modify state.
    assign w_wr      = w_accept && !memory_instr &&
                       (memory_wstrb != 4'h0);
    assign w_wr_msip = w_wr && (w_off == OFF_MSIP);
    assign w_wr_clo  = w_wr && (w_off == OFF_CMPLO);
    assign w_wr_chi  = w_wr && (w_off == OFF_CMPHI);
    assign w_wr_tlo  = w_wr && (w_off == OFF_TLO);
    assign w_wr_thi  = w_wr && (w_off == OFF_THI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sel) begin
                    w_accept = 1'b1;
                    w_next   = S_RESP;
                end
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd = '0;
        case (w_off)
            OFF_MSIP:  w_rd = {31'b0, r_msip};
            OFF_CMPLO: w_rd = r_cmp[31:0];
            OFF_CMPHI: w_rd = r_cmp[63:32];
            OFF_TLO:   w_rd = r_mtime[31:0];
            OFF_THI:   w_rd = r_mtime[63:32];
            default:   w_rd = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rdata <= '0;
        else     r_rdata <= w_accept ? w_rd : 32'h0;
    end

`ifdef CLINT_PRESCALER_EN
    logic [15:0] r_pre;

    assign w_tick = (r_pre == 16'(PRESCALE - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_pre <= '0;
        else if (w_wr_tlo || w_wr_thi || w_tick)
            r_pre <= '0;
        else
            r_pre <= r_pre + 16'd1;
    end
`else
    assign w_tick = 1'b1;
`endif

    // A software write replaces the tick for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_mtime <= '0;
        else if (w_wr_tlo)
            r_mtime[31:0] <= f_merge(r_mtime[31:0],
                                     memory_wdata, memory_wstrb);
        else if (w_wr_thi)
            r_mtime[63:32] <= f_merge(r_mtime[63:32],
                                      memory_wdata, memory_wstrb);
        else if (w_tick)
            r_mtime <= r_mtime + 64'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmp  <= '1;
            r_msip <= 1'b0;
            r_mtip <= 1'b0;
        end else begin
            if (w_wr_clo)
                r_cmp[31:0] <= f_merge(r_cmp[31:0],
                                       memory_wdata, memory_wstrb);
            if (w_wr_chi)
                r_cmp[63:32] <= f_merge(r_cmp[63:32],
                                        memory_wdata, memory_wstrb);
            if (w_wr_msip && memory_wstrb[0])
                r_msip <= memory_wdata[0];
            r_mtip <= (r_mtime >= r_cmp);
        end
    end

    assign memory_ready = (r_state == S_RESP);
    assign memory_rdata = r_rdata;
    assign mtime        = r_mtime;
    assign mtip         = r_mtip;
    assign msip         = r_msip;
endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: register table plus timing sequences.
`timescale 1ns/1ps
module tb_clint_timer;
`ifdef CLINT_PRESCALER_EN
    localparam int STEP = 4;
`else
    localparam int STEP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        memory_valid = 1'b0;
    logic        memory_instr = 1'b0;
    logic [31:0] memory_addr = '0;
    logic [31:0] memory_wdata = '0;
    logic [3:0]  memory_wstrb = '0;
    logic [31:0] memory_rdata;
    logic        memory_ready;
    logic [63:0] mtime;
    logic        mtip;
    logic        msip;

    int n_cmp = 0;
    int n_err = 0;
    int tb_cyc = 0;

    clint_timer #(
        .BASE_ADDR(32'h0200_0000),
        .PRESCALE (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .memory_valid(memory_valid),
        .memory_instr(memory_instr),
        .memory_addr (memory_addr),
        .memory_wdata(memory_wdata),
        .memory_wstrb(memory_wstrb),
        .memory_rdata(memory_rdata),
        .memory_ready(memory_ready),
        .mtime       (mtime),
        .mtip        (mtip),
        .msip        (msip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          instr;
        logic [31:0] exp_rd;
        bit          exp_msip;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the DUT idle; ends likewise.
    task automatic bus(input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] ws, input bit ins,
                       output logic [31:0] rd, output int lat);
        memory_valid = 1'b1;
        memory_addr  = a;
        memory_wdata = wd;
        memory_wstrb = ws;
        memory_instr = ins;
        rd  = '0;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (memory_ready) begin
                rd  = memory_rdata;
                lat = i;
                break;
            end
        end
        memory_valid = 1'b0;
        memory_wstrb = 4'h0;
        memory_instr = 1'b0;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws);
        logic [31:0] rd;
        int lat;
        bus(a, wd, ws, 1'b0, rd, lat);
        chk($sformatf("wr %h latency", a), 64'(lat), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          cnt;
        bit          seen;
        logic [63:0] t0;

        tbl[0]  = '{32'h0200_4000, 32'h0,          4'h0, 1'b0, 32'h0000_0020, 1'b0};
        tbl[1]  = '{32'h0200_4000, 32'h1122_3344, 4'hF, 1'b0, 32'h0000_0020, 1'b0};
        tbl[2]  = '{32'h0200_4000, 32'h0,          4'h0, 1'b0, 32'h1122_3344, 1'b0};
        tbl[3]  = '{32'h0200_4004, 32'hAABB_CCDD, 4'h5, 1'b0, 32'h0000_0000, 1'b0};
        tbl[4]  = '{32'h0200_4004, 32'h0,          4'h0, 1'b1, 32'h00BB_00DD, 1'b0};
        tbl[5]  = '{32'h0200_4000, 32'h0000_EE00, 4'h2, 1'b0, 32'h1122_3344, 1'b0};
        tbl[6]  = '{32'h0200_4000, 32'h0,          4'h0, 1'b0, 32'h1122_EE44, 1'b0};
        tbl[7]  = '{32'h0200_4000, 32'h0,          4'hF, 1'b1, 32'h1122_EE44, 1'b0};
        tbl[8]  = '{32'h0200_4000, 32'h0,          4'h0, 1'b0, 32'h1122_EE44, 1'b0};
        tbl[9]  = '{32'h0200_1234, 32'h0,          4'h0, 1'b0, 32'h0000_0000, 1'b0};
        tbl[10] = '{32'h0200_1234, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0000_0000, 1'b0};
        tbl[11] = '{32'h0200_1234, 32'h0,          4'h0, 1'b0, 32'h0000_0000, 1'b0};
        tbl[12] = '{32'h0200_0000, 32'h0,          4'h0, 1'b0, 32'h0000_0000, 1'b0};
        tbl[13] = '{32'h0200_0000, 32'h0000_0001, 4'h1, 1'b0, 32'h0000_0000, 1'b1};
        tbl[14] = '{32'h0200_0000, 32'h0,          4'h0, 1'b0, 32'h0000_0001, 1'b1};
        tbl[15] = '{32'h0200_0000, 32'h0000_0000, 4'h2, 1'b0, 32'h0000_0001, 1'b1};
        tbl[16] = '{32'h0200_0004, 32'h0,          4'h0, 1'b0, 32'h0000_0000, 1'b1};
        tbl[17] = '{32'h0200_0000, 32'hFFFF_FFFE, 4'hF, 1'b0, 32'h0000_0001, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", 64'(memory_ready), 64'd0);
        chk("reset rdata", 64'(memory_rdata), 64'd0);
        chk("reset mtime", mtime, 64'd0);
        chk("reset mtip", 64'(mtip), 64'd0);
        chk("reset msip", 64'(msip), 64'd0);
        rst = 1'b0;

        // mtime read issued at cycle 10 after reset release
        for (int i = 0; i < 20 && tb_cyc != 10; i++) tick();
        chk("cycle 10 reached", 64'(tb_cyc), 64'd10);
        chk("mtime model c10", mtime, 64'(10 / STEP));
        bus(32'h0200_BFF8, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("mtime lo latency", 64'(lat), 64'd1);
        chk("mtime lo rdata", 64'(rd), 64'(10 / STEP));
        bus(32'h0200_BFFC, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("mtime hi rdata", 64'(rd), 64'd0);

        // mtimecmp = 0x20, mtip rises one cycle after mtime hits it
        wr(32'h0200_4004, 32'h0, 4'hF);
        wr(32'h0200_4000, 32'h20, 4'hF);
        chk("mtip before 0x20", 64'(mtip), 64'd0);
        for (int i = 0; i < 400 && mtime != 64'h20; i++) tick();
        chk("mtime hits 0x20", mtime, 64'h20);
        chk("mtip same cycle", 64'(mtip), 64'd0);
        tick();
        chk("mtip next cycle", 64'(mtip), 64'd1);

        for (int i = 0; i < 18; i++) begin
            bus(tbl[i].addr, tbl[i].wdata, tbl[i].wstrb,
                tbl[i].instr, rd, lat);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd1);
            chk($sformatf("vec%0d rdata", i), 64'(rd), 64'(tbl[i].exp_rd));
            chk($sformatf("vec%0d msip", i), 64'(msip),
                64'(tbl[i].exp_msip));
        end

        // back-to-back: ready every second cycle
        memory_valid = 1'b1;
        memory_addr  = 32'h0200_4000;
        memory_wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("b2b ready %0d", i), 64'(memory_ready),
                64'((i % 2) == 0));
        end
        memory_valid = 1'b0;
        tick();

        // unselected window
        memory_valid = 1'b1;
        memory_addr  = 32'h0300_0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("unsel ready %0d", i), 64'(memory_ready), 64'd0);
        end
        memory_valid = 1'b0;
        tick();

        // wrap: mtimecmp = 0x00BB00DD_1122EE44 here
        wr(32'h0200_BFFC, 32'hFFFF_FFFF, 4'hF);
        wr(32'h0200_BFF8, 32'hFFFF_FFFE, 4'hF);
        for (int i = 0; i < 20 && mtime != '1; i++) tick();
        chk("mtime all ones", mtime, '1);
        for (int i = 0; i < 20 && mtime == '1; i++) tick();
        chk("mtime wrap", mtime, 64'd0);
        chk("mtip at wrap", 64'(mtip), 64'd1);
        tick();
        chk("mtip after wrap", 64'(mtip), 64'd0);

        // tick period
        t0 = mtime;
        for (int i = 0; i < 20 && mtime == t0; i++) tick();
        t0 = mtime;
        cnt = 0;
        for (int i = 0; i < 20 && mtime == t0; i++) begin
            tick();
            cnt++;
        end
        chk("tick period", 64'(cnt), 64'(STEP));
        chk("tick step", mtime, t0 + 64'd1);

        // reset while a response is pending
        wr(32'h0200_0000, 32'h1, 4'h1);
        chk("msip set pre-rst", 64'(msip), 64'd1);
        memory_valid = 1'b1;
        memory_addr  = 32'h0200_4000;
        tick();
        chk("resp before rst", 64'(memory_ready), 64'd1);
        rst = 1'b1;
        #1;
        memory_valid = 1'b0;
        chk("rst ready", 64'(memory_ready), 64'd0);
        chk("rst rdata", 64'(memory_rdata), 64'd0);
        chk("rst mtime", mtime, 64'd0);
        chk("rst msip", 64'(msip), 64'd0);
        chk("rst mtip", 64'(mtip), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | memory_ready;
        end
        chk("no ready after rst", 64'(seen), 64'd0);
        bus(32'h0200_4000, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("rst cmp lo", 64'(rd), 64'hFFFF_FFFF);
        bus(32'h0200_4004, 32'h0, 4'h0, 1'b0, rd, lat);
        chk("rst cmp hi", 64'(rd), 64'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
